regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file, for the pipelined datapath.
- Generalises register width and depth. Keeps the dedicated link-register port (the `jal` return address).
- Adds two things: a synchronous clear of all registers, and a per-register pending-write scoreboard. Decode uses the scoreboard to stall on outstanding multi-cycle results.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- LINK_REG, 31, index of the link register served by w_Link/r_Link.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Ra  in  ADDR_W  read port A index.
- Rb  in  ADDR_W  read port B index.
- busA  out  DATA_W  read data A, combinational.
- busB  out  DATA_W  read data B, combinational.
- Rw  in  ADDR_W  write index.
- Write  in  1  write enable for busW.
- busW  in  DATA_W  write data.
- LinkWrite  in  1  write enable for w_Link into LINK_REG.
- w_Link  in  DATA_W  link write data.
- r_Link  out  DATA_W  current contents of LINK_REG, combinational.
- SbSet  in  1  mark register SbReg as pending.
- SbReg  in  ADDR_W  index to mark pending.
- busyA  out  1  pending bit of Ra.
- busyB  out  1  pending bit of Rb.
- anyBusy  out  1  OR of all pending bits.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (sampled high at a rising edge of Clock): all registers cleared to 0 and all pending bits cleared.
  - Reset overrides any same-cycle Write, LinkWrite or SbSet.
  - The cycle after reset: busA = busB = r_Link = 0, busyA = busyB = anyBusy = 0.
  - Reset asserted mid-operation discards all pending state; no in-flight write survives.
- Register 0 is hardwired to 0.
  - Writes to index 0 from either port are ignored.
  - Reads of index 0 always return 0.
  - Register 0 is never pending; SbSet with SbReg = 0 is ignored.
- Write port: if Write = 1 and Rw != 0, reg[Rw] <= busW at the rising edge (1-cycle write latency).
- Link port: if LinkWrite = 1, reg[LINK_REG] <= w_Link at the rising edge.
- Write/link collision: both ports target LINK_REG in the same cycle (Write = 1, Rw = LINK_REG, LinkWrite = 1). busW wins; w_Link is dropped.
- Reads:
  - busA = reg[Ra], busB = reg[Rb], r_Link = reg[LINK_REG], all combinational, zero latency.
  - Ra = Rb is legal; both ports return the same value.
- Scoreboard, one pending bit per register:
  - SbSet = 1 sets pending[SbReg] at the rising edge.
  - A committed Write to Rw clears pending[Rw] at the rising edge.
  - A committed LinkWrite clears pending[LINK_REG].
  - SbSet and a clear on the same index in the same cycle: set wins, because a new producer has issued.
  - Setting an already-pending bit is a no-op, not an error.
- busyA = pending[Ra], busyB = pending[Rb], anyBusy = |pending. All combinational from registered state; a pending bit is visible the cycle after SbSet.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If Write = 1, Rw != 0 and Rw == Ra, busA returns busW in the same cycle; likewise for busB.
  - If LinkWrite = 1 (and no winning Write to LINK_REG), reads of LINK_REG and r_Link return w_Link.
  - The collision priority rule above also applies to forwarding.
  - busyA/busyB are also forced to 0 for an index being written that cycle, unless SbSet targets the same index.
- Undefined: reads and busy bits reflect only pre-edge stored state; a written value is visible the cycle after the write.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W/ADDR_W defaults;
  - LINK_REG constant;
  - ZERO_REG = 0;
  - a reg_idx_t typedef of width ADDR_W.
- One natural sub-module, regfile_scoreboard: holds the pending-bit vector with the set/clear/priority logic and drives busyA/busyB/anyBusy.
- The storage array and bypass muxes stay in regfile_sb.

Test Plan:
- Reset and zero register:
  - Write = 1, Rw = 1, busW = 4, edge; then Reset high for one edge -> busA(Ra = 1) = 0, anyBusy = 0.
  - Write Rw = 0, busW = 0xDEADBEEF -> busA(Ra = 0) = 0.
- Basic write/read: write reg2 = 5, reg1 = 4 on consecutive edges -> Ra = 1, Rb = 2 gives busA = 4, busB = 5.
- Link priority:
  - LinkWrite = 1, w_Link = 0xFFFF0000 -> r_Link = 0xFFFF0000 next cycle.
  - Same cycle Write, Rw = 31, busW = 7 and LinkWrite, w_Link = 9 -> r_Link = 7.
- Scoreboard:
  - SbSet, SbReg = 3 -> busyA(Ra = 3) = 1 next cycle.
  - Write Rw = 3 -> busyA = 0 next cycle.
  - SbSet, SbReg = 3 together with Write, Rw = 3 -> busyA stays 1.
- Bypass (REGFILE_BYPASS_EN defined vs undefined): Write, Rw = 4, busW = 0x12 with Ra = 4 in the same cycle -> busA = 0x12 (defined) or the old value (undefined); 0x12 in the cycle after in both builds.
- Reset during pending: set pending on regs 5 and 6, then Reset -> anyBusy = 0 and both registers read 0 after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, link/zero register indices and index type for regfile_sb
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int LINK_REG = 31;
  localparam int ZERO_REG = 0;
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, set by issue and cleared by committed writes
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINK_IDX = LINK_REG
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Rw,
  input  logic              Write,
  input  logic              LinkWrite,
  input  logic              SbSet,
  input  logic [ADDR_W-1:0] SbReg,
  output logic              busyA,
  output logic              busyB,
  output logic              anyBusy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] pending_q, pending_d, set_v, clr_v;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[SbReg] = SbSet;
    clr_v[Rw] = Write;
    clr_v[LINK_IDX] = clr_v[LINK_IDX] | LinkWrite;
    set_v[ZERO_REG] = 1'b0;
    pending_d = (pending_q & ~clr_v) | set_v;
    pending_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge Clock)
    pending_q <= Reset ? '0 : pending_d;
`ifdef REGFILE_BYPASS_EN
  // a write landing this cycle resolves the hazard unless a new producer issues to the same index
  assign busyA = pending_q[Ra] & ~(clr_v[Ra] & ~set_v[Ra]);
  assign busyB = pending_q[Rb] & ~(clr_v[Rb] & ~set_v[Rb]);
`else
  assign busyA = pending_q[Ra];
  assign busyB = pending_q[Rb];
`endif
  assign anyBusy = |pending_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with link port, sync clear and pending-write scoreboard
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINK_REG = regfile_pkg::LINK_REG
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic [ADDR_W-1:0] Rw,
  input  logic              Write,
  input  logic [DATA_W-1:0] busW,
  input  logic              LinkWrite,
  input  logic [DATA_W-1:0] w_Link,
  output logic [DATA_W-1:0] r_Link,
  input  logic              SbSet,
  input  logic [ADDR_W-1:0] SbReg,
  output logic              busyA,
  output logic              busyB,
  output logic              anyBusy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic wr_en, lk_en;
  assign wr_en = Write && Rw != ZR;
  assign lk_en = LinkWrite && LR != ZR;
  // link first so a same-cycle write to LINK_REG overrides it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (lk_en) regs_q[LR] <= w_Link;
      if (wr_en) regs_q[Rw] <= busW;
    end
  end
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] idx);
`ifdef REGFILE_BYPASS_EN
    return (wr_en && Rw == idx) ? busW : (lk_en && idx == LR) ? w_Link : regs_q[idx];
`else
    return regs_q[idx];
`endif
  endfunction
  assign busA = (Ra == ZR) ? '0 : rd(Ra);
  assign busB = (Rb == ZR) ? '0 : rd(Rb);
  assign r_Link = (LR == ZR) ? '0 : rd(LR);
  regfile_scoreboard #(.ADDR_W(ADDR_W), .LINK_IDX(LINK_REG)) u_sb (
    .Clock(Clock), .Reset(Reset), .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .Write(wr_en), .LinkWrite(lk_en), .SbSet(SbSet), .SbReg(SbReg),
    .busyA(busyA), .busyB(busyB), .anyBusy(anyBusy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb
module tb_regfile_sb;
  logic Clock = 1'b0, Reset, Write, LinkWrite, SbSet;
  logic [4:0] Ra, Rb, Rw, SbReg;
  logic [31:0] busW, w_Link, busA, busB, r_Link;
  logic busyA, busyB, anyBusy;
  int total = 0, bad = 0;
  regfile_sb dut (
    .Clock(Clock), .Reset(Reset), .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB),
    .Rw(Rw), .Write(Write), .busW(busW), .LinkWrite(LinkWrite), .w_Link(w_Link),
    .r_Link(r_Link), .SbSet(SbSet), .SbReg(SbReg), .busyA(busyA), .busyB(busyB),
    .anyBusy(anyBusy)
  );
  always #5 Clock = ~Clock;

  task automatic idle();
    Reset = 0; Write = 0; LinkWrite = 0; SbSet = 0;
    Rw = 0; busW = 0; w_Link = 0; SbReg = 0;
  endtask

  task automatic step();
    @(posedge Clock); #1; idle(); #1;
  endtask

  task automatic test_reset();
    idle(); Reset = 1; Ra = 0; Rb = 0; step();
    Write = 1; Rw = 1; busW = 4; step();
    Ra = 1; #1;
    total++; if (busA !== 32'd4) begin bad++; $display("FAIL rst_pre busA=%h exp=%h", busA, 32'd4); end
    Reset = 1; Write = 1; Rw = 1; busW = 9; SbSet = 1; SbReg = 1; step();
    total++; if (busA !== 32'd0) begin bad++; $display("FAIL rst_busA busA=%h exp=0", busA); end
    total++; if (anyBusy !== 1'b0) begin bad++; $display("FAIL rst_any anyBusy=%b exp=0", anyBusy); end
    total++; if (r_Link !== 32'd0 || busyA !== 1'b0) begin bad++; $display("FAIL rst_link r_Link=%h busyA=%b exp=0/0", r_Link, busyA); end
  endtask

  task automatic test_zero();
    Write = 1; Rw = 0; busW = 32'hDEADBEEF; Ra = 0; step();
    total++; if (busA !== 32'd0) begin bad++; $display("FAIL zero_rd busA=%h exp=0", busA); end
    SbSet = 1; SbReg = 0; Rb = 0; step();
    total++; if (anyBusy !== 1'b0 || busyB !== 1'b0) begin bad++; $display("FAIL zero_sb anyBusy=%b busyB=%b exp=0/0", anyBusy, busyB); end
  endtask

  task automatic test_basic();
    Write = 1; Rw = 2; busW = 5; step();
    Write = 1; Rw = 1; busW = 4; step();
    Ra = 1; Rb = 2; #1;
    total++; if (busA !== 32'd4 || busB !== 32'd5) begin bad++; $display("FAIL basic busA=%h busB=%h exp=4/5", busA, busB); end
    Ra = 2; #1;
    total++; if (busA !== 32'd5 || busB !== 32'd5) begin bad++; $display("FAIL same_idx busA=%h busB=%h exp=5/5", busA, busB); end
  endtask

  task automatic test_link();
    LinkWrite = 1; w_Link = 32'hFFFF0000; step();
    Ra = 31; #1;
    total++; if (r_Link !== 32'hFFFF0000 || busA !== 32'hFFFF0000) begin bad++; $display("FAIL link r_Link=%h busA=%h exp=ffff0000", r_Link, busA); end
    Write = 1; Rw = 31; busW = 7; LinkWrite = 1; w_Link = 9; step();
    total++; if (r_Link !== 32'd7) begin bad++; $display("FAIL link_prio r_Link=%h exp=7", r_Link); end
  endtask

  task automatic test_scoreboard();
    SbSet = 1; SbReg = 3; step();
    Ra = 3; Rb = 2; #1;
    total++; if (busyA !== 1'b1 || busyB !== 1'b0 || anyBusy !== 1'b1) begin bad++; $display("FAIL sb_set busyA=%b busyB=%b any=%b exp=1/0/1", busyA, busyB, anyBusy); end
    SbSet = 1; SbReg = 3; step();
    total++; if (busyA !== 1'b1) begin bad++; $display("FAIL sb_reset_again busyA=%b exp=1", busyA); end
    Write = 1; Rw = 3; busW = 33; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (busyA !== 1'b0) begin bad++; $display("FAIL sb_fwd busyA=%b exp=0", busyA); end
`else
    total++; if (busyA !== 1'b1) begin bad++; $display("FAIL sb_fwd busyA=%b exp=1", busyA); end
`endif
    step();
    total++; if (busyA !== 1'b0 || anyBusy !== 1'b0) begin bad++; $display("FAIL sb_clr busyA=%b any=%b exp=0/0", busyA, anyBusy); end
    SbSet = 1; SbReg = 3; Write = 1; Rw = 3; busW = 34; step();
    total++; if (busyA !== 1'b1) begin bad++; $display("FAIL sb_setwins busyA=%b exp=1", busyA); end
    Write = 1; Rw = 3; busW = 35; step();
    SbSet = 1; SbReg = 31; step();
    Rb = 31; #1;
    total++; if (busyB !== 1'b1) begin bad++; $display("FAIL sb_lk_set busyB=%b exp=1", busyB); end
    LinkWrite = 1; w_Link = 1; step();
    total++; if (busyB !== 1'b0 || anyBusy !== 1'b0) begin bad++; $display("FAIL sb_lk_clr busyB=%b any=%b exp=0/0", busyB, anyBusy); end
  endtask

  task automatic test_bypass();
    Ra = 4; Write = 1; Rw = 4; busW = 32'h12; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (busA !== 32'h12) begin bad++; $display("FAIL byp_same busA=%h exp=12", busA); end
`else
    total++; if (busA !== 32'h0) begin bad++; $display("FAIL byp_same busA=%h exp=0", busA); end
`endif
    step();
    total++; if (busA !== 32'h12) begin bad++; $display("FAIL byp_next busA=%h exp=12", busA); end
    Write = 1; Rw = 31; busW = 32'h55; LinkWrite = 1; w_Link = 32'h66; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (r_Link !== 32'h55) begin bad++; $display("FAIL byp_coll r_Link=%h exp=55", r_Link); end
`else
    total++; if (r_Link !== 32'h1) begin bad++; $display("FAIL byp_coll r_Link=%h exp=1", r_Link); end
`endif
    step();
    LinkWrite = 1; w_Link = 32'hAA; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (r_Link !== 32'hAA) begin bad++; $display("FAIL byp_link r_Link=%h exp=aa", r_Link); end
`else
    total++; if (r_Link !== 32'h55) begin bad++; $display("FAIL byp_link r_Link=%h exp=55", r_Link); end
`endif
    step();
    total++; if (r_Link !== 32'hAA) begin bad++; $display("FAIL byp_link_next r_Link=%h exp=aa", r_Link); end
  endtask

  task automatic test_reset_pending();
    Write = 1; Rw = 5; busW = 50; step();
    Write = 1; Rw = 6; busW = 60; step();
    SbSet = 1; SbReg = 5; step();
    SbSet = 1; SbReg = 6; step();
    Ra = 5; Rb = 6; #1;
    total++; if (busyA !== 1'b1 || busyB !== 1'b1 || busA !== 32'd50 || busB !== 32'd60) begin bad++; $display("FAIL rp_pre busy=%b%b busA=%h busB=%h exp=11/32/3c", busyA, busyB, busA, busB); end
    Reset = 1; step();
    total++; if (anyBusy !== 1'b0 || busyA !== 1'b0 || busyB !== 1'b0) begin bad++; $display("FAIL rp_busy any=%b busy=%b%b exp=0/00", anyBusy, busyA, busyB); end
    total++; if (busA !== 32'd0 || busB !== 32'd0 || r_Link !== 32'd0) begin bad++; $display("FAIL rp_data busA=%h busB=%h r_Link=%h exp=0", busA, busB, r_Link); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_link();
    test_scoreboard();
    test_bypass();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
